// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: fetches 32-bit words into a halfword FIFO and
// presents 16/32-bit RISC-V instructions, including ones straddling a word.
module prefetch_buffer #(
    parameter int                 ADDR_W   = 8,
    parameter int                 DEPTH    = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_compressed
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] SPACE_LIM = (CNT_W+1)'(DEPTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DROP
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       hw_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_nx, wr_ptr_nx;
    logic [CNT_W-1:0]  count_q;
    logic [ADDR_W-1:0] head_pc_q, fetch_addr_q;
    logic              skip_lo_q;

    logic [15:0]       head_lo, head_hi;
    logic              head_comp, have_instr, consume;
    logic [CNT_W-1:0]  rd_cnt, wr_cnt;
    logic              rsp_take, wr_en, issue, has_space, can_issue;
    logic [CNT_W:0]    committed;

    // ---------------- head decode ----------------
    assign rd_ptr_nx = rd_ptr_q + PTR_W'(1);
    assign wr_ptr_nx = wr_ptr_q + PTR_W'(1);
    assign head_lo   = hw_q[rd_ptr_q];
    assign head_hi   = hw_q[rd_ptr_nx];
    assign head_comp = (head_lo[1:0] != 2'b11);

    // A 32-bit instruction needs both halfwords resident, so a word-straddling
    // one waits for the next response.
    assign have_instr = (count_q >= CNT_W'(2)) ||
                        ((count_q == CNT_W'(1)) && head_comp);

    assign instr_valid      = ~rst & have_instr;
    assign instr_compressed = ~rst & (count_q != '0) & head_comp;
    assign instr_pc         = head_pc_q;

    always_comb begin
        instr_out = '0;
        if (instr_valid)
            instr_out = head_comp ? {16'h0000, head_lo} : {head_hi, head_lo};
    end

    assign consume = instr_valid & instr_ready & ~flush;
    assign rd_cnt  = consume ? (head_comp ? CNT_W'(1) : CNT_W'(2)) : '0;

    // ---------------- fetch side ----------------
    assign rsp_take = (state_q == BUSY) & mem_rvalid;
    assign wr_en    = rsp_take & ~flush & ~rst;
    assign wr_cnt   = wr_en ? (skip_lo_q ? CNT_W'(1) : CNT_W'(2)) : '0;

    // Reserve room for the outstanding response so a new word always fits.
    assign committed = {1'b0, count_q} + ((state_q == BUSY) ? (CNT_W+1)'(2) : '0);
    assign has_space = (committed <= SPACE_LIM);
    assign can_issue = (state_q == IDLE) | rsp_take;

    assign mem_req  = ~rst & ~flush & has_space & can_issue;
    assign mem_addr = fetch_addr_q;
    assign issue    = mem_req & mem_gnt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue)
                    state_d = BUSY;
            end
            BUSY: begin
                // A response landing in the flush cycle is already the one to
                // discard, so only an unanswered request needs DROP.
                if (flush)
                    state_d = mem_rvalid ? IDLE : DROP;
                else if (mem_rvalid)
                    state_d = issue ? BUSY : IDLE;
            end
            DROP: begin
                if (mem_rvalid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            head_pc_q    <= {RESET_PC[ADDR_W-1:1], 1'b0};
            fetch_addr_q <= {RESET_PC[ADDR_W-1:2], 2'b00};
            skip_lo_q    <= RESET_PC[1];
        end else if (flush) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            head_pc_q    <= flush_addr & ~ADDR_W'(1);
            fetch_addr_q <= flush_addr & ~ADDR_W'(3);
            skip_lo_q    <= flush_addr[1];
        end else begin
            if (wr_en) begin
                wr_ptr_q  <= wr_ptr_q + wr_cnt[PTR_W-1:0];
                skip_lo_q <= 1'b0;
            end
            if (consume) begin
                rd_ptr_q  <= rd_ptr_q + rd_cnt[PTR_W-1:0];
                head_pc_q <= head_pc_q + (head_comp ? ADDR_W'(2) : ADDR_W'(4));
            end
            count_q <= count_q + wr_cnt - rd_cnt;
            if (issue)
                fetch_addr_q <= fetch_addr_q + ADDR_W'(4);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (skip_lo_q) begin
                hw_q[wr_ptr_q] <= mem_rdata[31:16];
            end else begin
                hw_q[wr_ptr_q]  <= mem_rdata[15:0];
                hw_q[wr_ptr_nx] <= mem_rdata[31:16];
            end
        end
    end

endmodule
